// File: rtl/uart_pkg.sv
// Shared UART constants and state encodings, common to the receive and transmit paths.
package uart_pkg;

  localparam int unsigned CLK_HZ       = 12_000_000;
  localparam int unsigned BAUD         = 9600;
  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned DATA_BITS    = 8;
  localparam int unsigned CNT_W        = 11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter with clear, load and terminal / half-terminal flags.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS = uart_pkg::CLKS_PER_BIT,
  parameter int unsigned W    = CNT_W
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         term,
  output logic         half
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign term = (cnt_q == W'(CLKS - 1));
  assign half = (cnt_q == W'(CLKS / 2 - 1));

  // NOTE: always_comb with a default first cannot infer a latch on any path.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = term ? '0 : cnt_q + W'(1);
    end
  end

  // NOTE: state updates use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM, valid and framing-error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = uart_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic [2:0]           state
);

  localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic rx_meta_q;
  logic rx_s_q;

  uart_state_e state_q, state_d;

  logic             cnt_clr;
  logic             cnt_term;
  logic             cnt_half;

  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  // Idle-high reset value keeps a released reset from looking like a start bit.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  uart_baud_cnt #(
    .CLKS (CLKS_PER_BIT),
    .W    (CNT_W)
  ) u_baud_cnt (
    .clk      (clk),
    .nrst     (nrst),
    .clr      (cnt_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (state_q != ST_IDLE),
    .term     (cnt_term),
    .half     (cnt_half)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    cnt_clr   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_half) begin
          if (!rx_s_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (cnt_term) begin
          shift_d[bit_cnt_q] = rx_s_q;
          cnt_clr            = 1'b1;
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      ST_STOP: begin
        if (cnt_term) begin
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end
      end

      ST_WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every state starts its bit period from zero.
    if (state_d != state_q) begin
      cnt_clr = 1'b1;
    end
  end

  // NOTE: the shift register is a handful of flops, so it is reset like the rest of the state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != ST_IDLE);
  assign state     = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at a reduced bit period: loopback, glitch, framing error, reset, tolerance, random.
module tb_uart_rx;

  localparam int CPB = 50;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  int         cyc = 0;
  int         n_valid = 0;
  int         n_ferr = 0;
  int         n_pushed = 0;
  int         start_cyc = 0;
  logic       prev_strobe = 1'b0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] sb[$];
  int         vtimes[$];

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy),
    .state     (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on each valid and polices strobe rules.
  always @(negedge clk) begin
    if (nrst) begin
      if (valid || frame_err) begin
        check("strobe_excl", 32'(valid & frame_err), 32'd0);
        check("strobe_adjacent", 32'(prev_strobe), 32'd0);
      end
      if (valid) begin
        n_valid++;
        vtimes.push_back(cyc);
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          last_good = sb.pop_front();
          check("data_out", 32'(data_out), 32'(last_good));
        end
      end
      if (frame_err) begin
        n_ferr++;
        check("ferr_data_hold", 32'(data_out), 32'(last_good));
      end
      prev_strobe = valid | frame_err;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  task automatic send_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop_bit, input logic expect_byte);
    if (expect_byte) begin
      sb.push_back(b);
      n_pushed++;
    end
    start_cyc = cyc;
    send_bit(1'b0, cpb);
    for (int i = 0; i < 8; i++) send_bit(b[i], cpb);
    send_bit(stop_bit, cpb);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] loop_bytes[4];
    int         lat_start;
    int         ferr_before;
    int         valid_before;

    loop_bytes = '{8'h53, 8'h6E, 8'h61, 8'h70};

    // Reset state.
    #1;
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (CPB) @(negedge clk);

    // Gap-free loopback.
    vtimes.delete();
    lat_start = cyc;
    for (int i = 0; i < 4; i++) send_frame(loop_bytes[i], CPB, 1'b1, 1'b1);
    repeat (CPB) @(negedge clk);
    check("loop_count", 32'(vtimes.size()), 32'd4);
    if (vtimes.size() == 4) begin
      check("loop_latency", 32'(vtimes[0] - lat_start), 32'(3 + CPB / 2 + 9 * CPB));
      for (int i = 1; i < 4; i++) check("loop_spacing", 32'(vtimes[i] - vtimes[i-1]), 32'(10 * CPB));
    end
    check("loop_no_ferr", 32'(n_ferr), 32'd0);

    // Short low glitch from idle.
    valid_before = n_valid;
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (CPB / 2 + 3 - CPB / 4) @(negedge clk);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_state", 32'(state), 32'd0);
    repeat (CPB) @(negedge clk);
    check("glitch_no_valid", 32'(n_valid), 32'(valid_before));
    check("glitch_no_ferr", 32'(n_ferr), 32'd0);

    // Framing error, then line held low, then a good frame.
    ferr_before = n_ferr;
    valid_before = n_valid;
    send_frame(8'hA5, CPB, 1'b0, 1'b0);
    send_bit(1'b0, 5 * CPB);
    check("ferr_count", 32'(n_ferr), 32'(ferr_before + 1));
    check("ferr_no_valid", 32'(n_valid), 32'(valid_before));
    check("ferr_wait_high", 32'(state), 32'd4);
    check("ferr_data_kept", 32'(data_out), 32'h70);
    send_bit(1'b1, 4);
    check("ferr_back_idle", 32'(state), 32'd0);
    send_bit(1'b1, CPB);
    send_frame(8'h3C, CPB, 1'b1, 1'b1);
    send_bit(1'b1, CPB);

    // Reset in the middle of data bit 4 of 0xFF.
    valid_before = n_valid;
    send_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) send_bit(1'b1, CPB);
    send_bit(1'b1, CPB / 2);
    nrst = 1'b0;
    #1;
    check("mid_rst_data_out", 32'(data_out), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_state", 32'(state), 32'd0);
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    send_bit(1'b1, 5 * CPB);
    check("mid_rst_no_valid", 32'(n_valid), 32'(valid_before));
    send_frame(8'h81, CPB, 1'b1, 1'b1);
    send_bit(1'b1, CPB);

    // Baud mismatch of about two percent each way.
    ferr_before = n_ferr;
    send_frame(8'h55, CPB - 1, 1'b1, 1'b1);
    send_bit(1'b1, CPB);
    send_frame(8'hAA, CPB - 1, 1'b1, 1'b1);
    send_bit(1'b1, CPB);
    send_frame(8'h55, CPB + 1, 1'b1, 1'b1);
    send_bit(1'b1, CPB);
    send_frame(8'hAA, CPB + 1, 1'b1, 1'b1);
    send_bit(1'b1, CPB);
    check("tol_no_ferr", 32'(n_ferr), 32'(ferr_before));

    // Random bytes with 0-3 bit idle gaps.
    for (int i = 0; i < 80; i++) begin
      send_frame(8'($urandom % 256), CPB, 1'b1, 1'b1);
      send_bit(1'b1, int'($urandom_range(0, 3)) * CPB);
    end
    repeat (2 * CPB) @(negedge clk);

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("valid_total", 32'(n_valid), 32'(n_pushed));
    check("ferr_total", 32'(n_ferr), 32'd1);
    check("final_idle", 32'(state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, LSB first; directly downstream of the UART transmitter.
- Samples the serial line, which idles high, on the 12 MHz system clock at 9600 baud.
- Produces a parallel byte with a one-cycle valid strobe, plus a framing-error strobe.
- Serves as the loopback checker and host-command input for the transmit path.

Parameters:
- CLKS_PER_BIT, 1250, system clocks per bit (12 MHz / 9600).
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock, 12 MHz, rising edge.
- nrst  input  1  asynchronous active-low reset.
- rx  input  1  serial line from the transmitter or pin; asynchronous to clk.
- data_out  output  DATA_BITS  last correctly framed byte; holds until the next good frame.
- valid  output  1  one-cycle pulse when data_out is updated.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- busy  output  1  high in every state except IDLE.
- state  output  3  current FSM state, for debug/bench visibility.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While nrst=0, all flops clear immediately.
  - data_out=0, valid=0, frame_err=0, busy=0, state=IDLE.
  - Bit counter=0, baud counter=0.
  - Both synchroniser flops reset to 1, so no false start is seen on release.
- Synchroniser: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- Baud counter: 11 bits, 0..CLKS_PER_BIT-1. Cleared on every state entry.
- FSM states: IDLE=0, START=1, DATA=2, STOP=3, WAIT_HIGH=4. Unused encodings go to IDLE.
- IDLE: when rx_s=0, go to START and clear the counter.
- START: count to CLKS_PER_BIT/2-1 (624), then sample rx_s.
  - rx_s=0: go to DATA, clear the counter and the bit counter.
  - rx_s=1: glitch; return to IDLE with no strobe.
- DATA: on each count==CLKS_PER_BIT-1, shift rx_s into bit (bit_count) of the shift register (LSB first), increment bit_count, clear the counter.
  - After bit DATA_BITS-1 is sampled, go to STOP.
- STOP: at count==CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1: load data_out from the shift register, pulse valid for 1 cycle, go to IDLE.
  - rx_s=0: pulse frame_err for 1 cycle, leave data_out unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. A break or stuck-low line never produces a byte.
- Sampling point: mid-bit (start detect + 625 clocks + k*1250). This tolerates about ±4% baud mismatch over a frame.
- Latency: valid rises exactly 2 + 625 + 9*1250 = 11877 clocks after the first clk edge that sees rx=0, to within ±1 clock.
- Back-to-back frames: a start bit immediately after the stop-bit sample is accepted.
  - The STOP→IDLE→START path must not lose it: IDLE sees rx_s=0 on its first cycle.
- valid and frame_err are mutually exclusive and never high on consecutive cycles.
- Mid-frame reset: the frame is aborted with no strobe. After release, receive resumes only on a fresh falling edge seen from IDLE.

Decomposition:
- Shared package (uart_pkg):
  - CLK_HZ=12_000_000, BAUD=9600, CLKS_PER_BIT derived.
  - State encodings IDLE/START/DATA/STOP/WAIT_HIGH.
  - The same constants are reused by the transmitter.
- Sub-module: uart_baud_cnt, a loadable counter with clear and a terminal/half-terminal flag. The transmitter can share it.
- Synchroniser and FSM stay inline.

Test Plan:
- Loopback: drive rx from the transmitter with bytes 0x53, 0x6E, 0x61, 0x70 gap-free.
  - Expect 4 valid pulses, data_out equal to each byte, frame_err never high, spacing 10*1250 clocks.
- Glitch: hold rx low for 300 clocks from idle.
  - Expect no valid or frame_err, busy back to 0 within 625+3 clocks, state=IDLE.
- Framing error: send 0xA5 with the stop bit forced low, then hold low 5 bit times, then high.
  - Expect frame_err for 1 cycle, data_out keeps its previous value, state=WAIT_HIGH until rx high, then a following 0x3C is received.
- Reset mid-frame: assert nrst=0 during data bit 4 of 0xFF.
  - Expect all outputs at reset values immediately, no valid; the next frame 0x81 is received correctly.
- Baud tolerance: transmit 0x55 and 0xAA at 1225 and 1275 clocks/bit.
  - Expect both received correctly, no frame_err.
- Random: 1000 frames of $urandom%256 with random 0–3 bit idle gaps.
  - Expect scoreboard match on all bytes.
